// File: rtl/kick_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kick_timer                                                   |
// | Description : Restartable up-counter with a latched runtime limit,         |
// |               one-shot or auto-reload, pause/resume and a terminal pulse.  |
// |               Optional step prescaler: define KICK_TIMER_PRESCALE_EN.      |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module kick_timer #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEFAULT_LIMIT = 43840,
    parameter int unsigned PRESCALE      = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             en,
    input  logic             stop,
    input  logic             reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wraps
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] WRAPS_MAX = 8'hFF;

`ifdef KICK_TIMER_PRESCALE_EN
    localparam int unsigned    PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = (PRESCALE > 1) ? PSC_W'(PRESCALE - 1) : '0;

    logic [PSC_W-1:0] r_psc;
`else
    // PRESCALE only matters when the prescaler is built in.
    if (PRESCALE == 0) begin : g_prescale_unused
    end
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_wraps;

    logic             w_terminal;

    assign w_terminal = (r_count == r_limit);

    // HOLD with stop released evaluates exactly like COUNT on the same edge,
    // so a pause costs only the cycles stop was actually high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_limit <= WIDTH'(DEFAULT_LIMIT);
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wraps <= '0;
`ifdef KICK_TIMER_PRESCALE_EN
            r_psc   <= '0;
`endif
        end else if (go) begin
            r_state <= S_COUNT;
            r_count <= '0;
            r_limit <= limit;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_wraps <= '0;
`ifdef KICK_TIMER_PRESCALE_EN
            r_psc   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_COUNT, S_HOLD: begin
                    if (stop) begin
                        r_state <= S_HOLD;
                    end else if (w_terminal) begin
                        r_done <= 1'b1;
                        if (reload) begin
                            r_state <= S_COUNT;
                            r_count <= '0;
                            if (r_wraps != WRAPS_MAX) begin
                                r_wraps <= r_wraps + 8'd1;
                            end
`ifdef KICK_TIMER_PRESCALE_EN
                            r_psc   <= '0;
`endif
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_COUNT;
                        if (en) begin
`ifdef KICK_TIMER_PRESCALE_EN
                            if (r_psc == PSC_MAX) begin
                                r_psc   <= '0;
                                r_count <= r_count + WIDTH'(1);
                            end else begin
                                r_psc   <= r_psc + PSC_W'(1);
                            end
`else
                            r_count <= r_count + WIDTH'(1);
`endif
                        end
                    end
                end
                S_DONE: begin
                    r_count <= r_limit;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wraps = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_kick_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_kick_timer                                                |
// | Description : Self-checking bench: vector table, directed sequences and    |
// |               randomized traffic against a behavioural model.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_kick_timer;

    localparam int WIDTH = 16;
    localparam int DEF_LIMIT = 43840;
`ifdef KICK_TIMER_PRESCALE_EN
    localparam int P_EFF = 3;
`else
    localparam int P_EFF = 1;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             go = 1'b0;
    logic             en = 1'b0;
    logic             stop = 1'b0;
    logic             reload = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [7:0]       wraps;

    kick_timer #(
        .WIDTH        (WIDTH),
        .DEFAULT_LIMIT(DEF_LIMIT),
        .PRESCALE     (P_EFF)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .go    (go),
        .en    (en),
        .stop  (stop),
        .reload(reload),
        .limit (limit),
        .count (count),
        .busy  (busy),
        .done  (done),
        .wraps (wraps)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Behavioural model: running / finished flags plus counters.
    bit m_run, m_fin, m_done;
    int m_cnt, m_lim, m_wraps, m_en_cycles;

    function automatic void model_edge();
        if (!resetn) begin
            m_run = 0; m_fin = 0; m_done = 0;
            m_cnt = 0; m_lim = DEF_LIMIT; m_wraps = 0; m_en_cycles = 0;
        end else if (go) begin
            m_run = 1; m_fin = 0; m_done = 0;
            m_cnt = 0; m_lim = int'(limit); m_wraps = 0; m_en_cycles = 0;
        end else begin
            m_done = 0;
            if (m_fin) begin
                m_cnt = m_lim;
            end else if (m_run && !stop) begin
                if (m_cnt == m_lim) begin
                    m_done = 1;
                    if (reload) begin
                        m_cnt = 0;
                        m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
                        m_en_cycles = 0;
                    end else begin
                        m_run = 0;
                        m_fin = 1;
                    end
                end else if (en) begin
                    m_en_cycles++;
                    if (m_en_cycles == P_EFF) begin
                        m_en_cycles = 0;
                        m_cnt++;
                    end
                end
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_count"}, int'(count), m_cnt);
        check({tag, "_busy"},  int'(busy),  int'(m_run));
        check({tag, "_done"},  int'(done),  int'(m_done));
        check({tag, "_wraps"}, int'(wraps), m_wraps);
    endtask

    task automatic wait_count(input string name, input int target, output int n);
        n = 0;
        for (int i = 0; i < 600 && int'(count) != target; i++) begin
            tick();
            cmp_model(name);
            n++;
        end
        check({name, "_reached"}, int'(count), target);
    endtask

    task automatic run_until_done(input string name, input bit rnd_en,
                                  output int edges, output int en_low);
        bit hit;
        bit e_s;
        bit s_s;
        hit = 0; edges = 0; en_low = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (rnd_en) en = 1'($urandom_range(0, 1));
            e_s = en;
            s_s = stop;
            tick();
            cmp_model(name);
            edges++;
            if (done) hit = 1;
            else if (!s_s && !e_s) en_low++;
        end
        check({name, "_done_seen"}, int'(hit), 1);
    endtask

    typedef struct {
        logic             rn, g, e, s, rl;
        logic [WIDTH-1:0] lim;
        int               cnt;
        int               bsy;
        int               dn;
        int               wr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int n, edges, en_low, pre, pulses;

        // rn  go  en  stop rl  limit    cnt busy done wraps
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd9, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd9, 0, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 0, 0, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 0, 0, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 0, 1, 0, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd9, 0, 1, 1, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd9, 0, 1, 1, 2};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd9, 0, 1, 0, 2};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd9, 0, 1, 0, 2};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 0, 0, 1, 2};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 0, 0, 0, 2};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1, 0, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 0, 0, 1, 0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 0, 1, 0, 0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 0, 1, 0, 0};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 0, 0, 0, 0};

        for (int i = 0; i < 18; i++) begin
            resetn = tbl[i].rn; go = tbl[i].g; en = tbl[i].e;
            stop = tbl[i].s; reload = tbl[i].rl; limit = tbl[i].lim;
            tick();
            check($sformatf("vec%0d_count", i), int'(count), tbl[i].cnt);
            check($sformatf("vec%0d_busy", i),  int'(busy),  tbl[i].bsy);
            check($sformatf("vec%0d_done", i),  int'(done),  tbl[i].dn);
            check($sformatf("vec%0d_wraps", i), int'(wraps), tbl[i].wr);
        end

        // One-shot, limit 5.
        resetn = 1; go = 1; limit = 5; reload = 0; en = 1; stop = 0;
        tick();
        cmp_model("oneshot_go");
        go = 0;
        run_until_done("oneshot", 1'b0, edges, en_low);
        check("oneshot_done_edge", edges, 5 * P_EFF + 1);
        check("oneshot_busy_at_done", int'(busy), 0);
        tick();
        check("oneshot_hold_count", int'(count), 5);
        check("oneshot_hold_busy", int'(busy), 0);
        check("oneshot_single_pulse", int'(done), 0);

        // Auto-reload, limit 3, 20 cycles.
        go = 1; limit = 3; reload = 1;
        tick();
        go = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cmp_model("reload");
            if (done) pulses++;
        end
        check("reload_wraps_20", int'(wraps), 20 / (3 * P_EFF + 1));
        check("reload_pulses_20", pulses, 20 / (3 * P_EFF + 1));

        // Pause at count 4 for 4 cycles, en toggling afterwards.
        go = 1; limit = 10; reload = 0; en = 1;
        tick();
        go = 0;
        wait_count("pause_pre", 4, pre);
        stop = 1;
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("pause_frozen%0d", i), int'(count), 4);
            cmp_model("pause_hold");
        end
        stop = 0;
        run_until_done("pause_run", 1'b1, edges, en_low);
        check("pause_done_delay", pre + 4 + edges, 10 * P_EFF + 1 + 4 + en_low);
        en = 1;

        // Restart mid-run with a smaller limit.
        go = 1; limit = 20;
        tick();
        go = 0;
        wait_count("restart_pre", 7, n);
        go = 1; limit = 2;
        tick();
        check("restart_count0", int'(count), 0);
        check("restart_busy", int'(busy), 1);
        go = 0;
        run_until_done("restart_run", 1'b0, edges, en_low);
        check("restart_done_edge", edges, 2 * P_EFF + 1);
        check("restart_final_count", int'(count), 2);

        // Reset beats go.
        go = 1; limit = 5;
        tick();
        go = 0;
        wait_count("rst_pre", 1, n);
        resetn = 0; go = 1;
        tick();
        cmp_model("rst_vs_go");
        check("rst_vs_go_busy", int'(busy), 0);
        resetn = 1; go = 0;
        tick();
        check("rst_idle_count", int'(count), 0);
        check("rst_idle_busy", int'(busy), 0);

        // Wrap counter saturation with limit 0.
        go = 1; limit = 0; reload = 1;
        tick();
        go = 0;
        for (int i = 0; i < 300; i++) begin
            en = 1'($urandom_range(0, 1));
            tick();
            cmp_model("sat");
        end
        check("sat_wraps", int'(wraps), 255);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 149) != 0);
            go     = ($urandom_range(0, 39) == 0);
            en     = ($urandom_range(0, 3) != 0);
            stop   = ($urandom_range(0, 7) == 0);
            reload = 1'($urandom_range(0, 1));
            limit  = WIDTH'($urandom_range(0, 12));
            tick();
            cmp_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
